// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Four-digit multiplexed seven-segment driver. Follows the external scan
//   code, shows a 16-bit hex value with per-digit decimal points, and adds
//   frame-synchronous (tear-free) value update, anode dead-time on every
//   digit change, leading-zero blanking and per-digit blink.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   scan[1:0]   digit select from the clock divider, 0 = rightmost digit
//   hex_in      value to display, nibble i -> digit i
//   point_in    decimal point per digit, 1 = lit
//   load        single-cycle strobe capturing hex_in/point_in
//   blank_lz    1 = suppress leading zeros
//   blink_mask  1 = digit i blinks
//   pending     captured value not yet on the display
//   AN[3:0]     anodes, active-low, registered
//   SEGMENT     segments, active-low, registered; bit0=a..bit6=g, bit7=dp
module seg7_scan_driver #(
  parameter int DEAD_CYCLES  = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scan,
  input  logic [15:0] hex_in,
  input  logic [3:0]  point_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  output logic        pending,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT
);

  localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    DEAD_LOAD  = 8'(DEAD_CYCLES);

  logic [1:0]    scan_q;
  logic [7:0]    dead_cnt;
  logic [15:0]   shadow_hex, disp_hex;
  logic [3:0]    shadow_dp, disp_dp;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          scan_chg, frame_start;
  logic [15:0]   disp_shift;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic          digit_blank, blink_off;
  logic [3:0]    an_next;
  logic [7:0]    seg_next;

  // Active-low font, segments a..g only; dp is added separately.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign scan_chg    = (scan != scan_q);
  assign frame_start = scan_chg && (scan == 2'd0);

  always_comb begin
    disp_shift  = disp_hex >> {scan, 2'b00};
    nib         = disp_shift[3:0];
    // lz[i]: nibble i and every nibble above it are zero; digit 0 always shows.
    lz          = 4'b0000;
    lz[3]       = (disp_hex[15:12] == 4'h0);
    lz[2]       = lz[3] && (disp_hex[11:8] == 4'h0);
    lz[1]       = lz[2] && (disp_hex[7:4] == 4'h0);
    digit_blank = blank_lz && lz[scan];
    blink_off   = blink_phase && blink_mask[scan];
    an_next     = 4'hF;
    if (!(scan_chg || (dead_cnt != 8'd0) || blink_off))
      an_next = ~(4'b0001 << scan);
    seg_next    = 8'hFF;
    if (!(digit_blank || blink_off))
      seg_next = {~disp_dp[scan], font(nib)};
  end

  // Scan edge tracking and anode dead-time counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q   <= 2'd0;
      dead_cnt <= 8'd0;
    end else begin
      scan_q <= scan;
      if (scan_chg)
        dead_cnt <= DEAD_LOAD;
      else if (dead_cnt != 8'd0)
        dead_cnt <= dead_cnt - 8'd1;
    end
  end

  // Shadow/display registers: new values only reach the display at a frame
  // boundary so a digit never mixes old and new nibbles within one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hex <= 16'h0000;
      shadow_dp  <= 4'h0;
      disp_hex   <= 16'h0000;
      disp_dp    <= 4'h0;
      pending    <= 1'b0;
    end else if (load && frame_start) begin
      disp_hex <= hex_in;
      disp_dp  <= point_in;
      pending  <= 1'b0;
    end else if (frame_start && pending) begin
      disp_hex <= shadow_hex;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end else if (load) begin
      shadow_hex <= hex_in;
      shadow_dp  <= point_in;
      pending    <= 1'b1;
    end
  end

  // Blink timebase counted in whole scan frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN      <= 4'hF;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= an_next;
      SEGMENT <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DEAD = 4;
  localparam int BF   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  scan = 2'd0;
  logic [15:0] hex_in = 16'h0;
  logic [3:0]  point_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic        pending;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;

  int vecs = 0;
  int errs = 0;

  logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: what the display should hold, in plain terms.
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend;
  int          m_prev, m_frames, m_since;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_pend;

  seg7_scan_driver #(.DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .scan(scan), .hex_in(hex_in), .point_in(point_in),
    .load(load), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .pending(pending), .AN(AN), .SEGMENT(SEGMENT)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_disp = 16'h0; m_shadow = 16'h0; m_dp = 4'h0; m_shdp = 4'h0; m_pend = 1'b0;
    m_prev = 0; m_frames = 0; m_since = 1000;
    e_an = 4'hF; e_seg = 8'hFF; e_pend = 1'b0;
  endtask

  // Predict the outputs after the coming clock edge from the present inputs,
  // then advance one cycle and settle.
  task automatic tick();
    int s;
    bit chg, fs, phase, forced, blank, boff;
    logic [15:0] upper;
    s      = int'(scan);
    chg    = (s != m_prev);
    fs     = chg && (s == 0);
    m_since = chg ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    forced = (m_since <= DEAD);
    phase  = ((m_frames / BF) % 2) == 1;
    upper  = m_disp >> (4 * s);
    blank  = blank_lz && (s != 0) && (upper == 16'h0);
    boff   = phase && blink_mask[s];
    e_an   = 4'hF;
    if (!(forced || boff)) e_an[s] = 1'b0;
    e_seg  = font_tab[upper[3:0]];
    if (m_dp[s]) e_seg[7] = 1'b0;
    if (blank || boff) e_seg = 8'hFF;
    if (fs) m_frames++;
    if (load && fs) begin
      m_disp = hex_in; m_dp = point_in; m_pend = 1'b0;
    end else if (fs && m_pend) begin
      m_disp = m_shadow; m_dp = m_shdp; m_pend = 1'b0;
    end else if (load) begin
      m_shadow = hex_in; m_shdp = point_in; m_pend = 1'b1;
    end
    e_pend = m_pend;
    m_prev = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    vecs++; if (AN !== 4'hF) begin errs++; $display("FAIL reset_an AN=%h want F", AN); end
    vecs++; if (SEGMENT !== 8'hFF) begin errs++; $display("FAIL reset_seg SEGMENT=%h want FF", SEGMENT); end
    vecs++; if (pending !== 1'b0) begin errs++; $display("FAIL reset_pending pending=%b want 0", pending); end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_scan_dead();
    logic [3:0] an_lit;
    blank_lz = 1'b0; blink_mask = 4'h0; load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 20; c++) begin
        scan = 2'(d);
        tick();
        vecs++; if (AN !== e_an) begin errs++; $display("FAIL scan_an d=%0d c=%0d AN=%h want %h", d, c, AN, e_an); end
        vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL scan_seg d=%0d c=%0d SEGMENT=%h want %h", d, c, SEGMENT, e_seg); end
        vecs++; if (pending !== e_pend) begin errs++; $display("FAIL scan_pend d=%0d c=%0d pending=%b want %b", d, c, pending, e_pend); end
        if (d > 0) begin
          an_lit = 4'hF;
          if (c >= 5) an_lit[d] = 1'b0;
          vecs++; if (AN !== an_lit) begin errs++; $display("FAIL dead_time d=%0d c=%0d AN=%h want %h", d, c, AN, an_lit); end
        end
      end
      vecs++; if (SEGMENT !== 8'hC0) begin errs++; $display("FAIL zero_digit d=%0d SEGMENT=%h want C0", d, SEGMENT); end
    end
  endtask

  task automatic test_load_frame();
    int seq [6] = '{2, 3, 0, 1, 2, 3};
    hex_in = 16'h1234; point_in = 4'h0;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 20; c++) begin
        scan = 2'(seq[k]);
        load = (k == 0 && c == 3);
        tick();
        vecs++; if (AN !== e_an) begin errs++; $display("FAIL load_an k=%0d c=%0d AN=%h want %h", k, c, AN, e_an); end
        vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL load_seg k=%0d c=%0d SEGMENT=%h want %h", k, c, SEGMENT, e_seg); end
        vecs++; if (pending !== e_pend) begin errs++; $display("FAIL load_pend k=%0d c=%0d pending=%b want %b", k, c, pending, e_pend); end
      end
      if (k == 1) begin
        vecs++; if (pending !== 1'b1) begin errs++; $display("FAIL load_pending_held pending=%b want 1", pending); end
      end
      if (k == 2) begin
        vecs++; if (SEGMENT !== 8'h99) begin errs++; $display("FAIL load_digit0 SEGMENT=%h want 99", SEGMENT); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_on_frame();
    hex_in = 16'hABCD; point_in = 4'h0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 20; c++) begin
        scan = 2'(d);
        load = (d == 0 && c == 0);
        tick();
        vecs++; if (AN !== e_an) begin errs++; $display("FAIL lof_an d=%0d c=%0d AN=%h want %h", d, c, AN, e_an); end
        vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL lof_seg d=%0d c=%0d SEGMENT=%h want %h", d, c, SEGMENT, e_seg); end
        vecs++; if (pending !== 1'b0) begin errs++; $display("FAIL lof_pend d=%0d c=%0d pending=%b want 0", d, c, pending); end
      end
      if (d == 0) begin
        vecs++; if (SEGMENT !== 8'hA1) begin errs++; $display("FAIL lof_digit0 SEGMENT=%h want A1", SEGMENT); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_blank();
    blank_lz = 1'b1; point_in = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      hex_in = (f < 2) ? 16'h0050 : 16'h0000;
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 20; c++) begin
          scan = 2'(d);
          load = (d == 1 && c == 2 && (f == 0 || f == 2));
          tick();
          vecs++; if (AN !== e_an) begin errs++; $display("FAIL blank_an f=%0d d=%0d c=%0d AN=%h want %h", f, d, c, AN, e_an); end
          vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL blank_seg f=%0d d=%0d c=%0d SEGMENT=%h want %h", f, d, c, SEGMENT, e_seg); end
          vecs++; if (pending !== e_pend) begin errs++; $display("FAIL blank_pend f=%0d d=%0d c=%0d pending=%b want %b", f, d, c, pending, e_pend); end
        end
        if (f == 1 && d == 1) begin
          vecs++; if (SEGMENT !== 8'h12) begin errs++; $display("FAIL blank_dp_digit SEGMENT=%h want 12", SEGMENT); end
        end
        if (f == 3 && d == 1) begin
          vecs++; if (SEGMENT !== 8'hFF) begin errs++; $display("FAIL blank_zero_digit1 SEGMENT=%h want FF", SEGMENT); end
        end
      end
    end
    load = 1'b0; blank_lz = 1'b0; point_in = 4'h0;
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001; hex_in = 16'h1111;
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 20; c++) begin
          scan = 2'(d);
          load = (f == 0 && d == 1 && c == 0);
          tick();
          vecs++; if (AN !== e_an) begin errs++; $display("FAIL blink_an f=%0d d=%0d c=%0d AN=%h want %h", f, d, c, AN, e_an); end
          vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL blink_seg f=%0d d=%0d c=%0d SEGMENT=%h want %h", f, d, c, SEGMENT, e_seg); end
          vecs++; if (pending !== e_pend) begin errs++; $display("FAIL blink_pend f=%0d d=%0d c=%0d pending=%b want %b", f, d, c, pending, e_pend); end
        end
      end
    end
    load = 1'b0; blink_mask = 4'h0;
  endtask

  task automatic test_rst_mid();
    int seq [5] = '{2, 3, 0, 1, 2};
    hex_in = 16'h5678;
    for (int c = 0; c < 5; c++) begin
      scan = 2'd2;
      load = (c == 2);
      tick();
      vecs++; if (pending !== e_pend) begin errs++; $display("FAIL rstmid_pre_pend c=%0d pending=%b want %b", c, pending, e_pend); end
    end
    load = 1'b0;
    rst = 1'b1;
    #1;
    vecs++; if (AN !== 4'hF) begin errs++; $display("FAIL rstmid_an AN=%h want F", AN); end
    vecs++; if (SEGMENT !== 8'hFF) begin errs++; $display("FAIL rstmid_seg SEGMENT=%h want FF", SEGMENT); end
    vecs++; if (pending !== 1'b0) begin errs++; $display("FAIL rstmid_pend pending=%b want 0", pending); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 20; c++) begin
        scan = 2'(seq[k]);
        tick();
        vecs++; if (AN !== e_an) begin errs++; $display("FAIL rstmid_run_an k=%0d c=%0d AN=%h want %h", k, c, AN, e_an); end
        vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL rstmid_run_seg k=%0d c=%0d SEGMENT=%h want %h", k, c, SEGMENT, e_seg); end
        vecs++; if (pending !== e_pend) begin errs++; $display("FAIL rstmid_run_pend k=%0d c=%0d pending=%b want %b", k, c, pending, e_pend); end
      end
      vecs++; if (SEGMENT !== 8'hC0) begin errs++; $display("FAIL rstmid_zero k=%0d SEGMENT=%h want C0", k, SEGMENT); end
    end
  endtask

  // Random scan jumps with short holds (changes inside the dead window),
  // random loads, blanking and blink masks.
  task automatic test_random();
    int hold;
    for (int n = 0; n < 400; n++) begin
      scan       = 2'($urandom_range(0, 3));
      hold       = $urandom_range(1, 12);
      blank_lz   = 1'($urandom_range(0, 1));
      blink_mask = 4'($urandom);
      for (int c = 0; c < hold; c++) begin
        load     = ($urandom_range(0, 7) == 0);
        hex_in   = 16'($urandom);
        if ($urandom_range(0, 3) == 0) hex_in = hex_in & 16'h00FF;
        point_in = 4'($urandom);
        tick();
        vecs++; if (AN !== e_an) begin errs++; $display("FAIL rand_an n=%0d c=%0d AN=%h want %h", n, c, AN, e_an); end
        vecs++; if (SEGMENT !== e_seg) begin errs++; $display("FAIL rand_seg n=%0d c=%0d SEGMENT=%h want %h", n, c, SEGMENT, e_seg); end
        vecs++; if (pending !== e_pend) begin errs++; $display("FAIL rand_pend n=%0d c=%0d pending=%b want %b", n, c, pending, e_pend); end
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_dead();
    test_load_frame();
    test_load_on_frame();
    test_blank();
    test_blink();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Four-digit multiplexed seven-segment display driver, directly downstream of the clock-divider scan generator.
- Consumes the free-running 2-bit `scan` code and a 16-bit hex value from the counter datapath.
- Drives active-low anode and segment lines.
- Adds tear-free frame-synchronous value update, anode dead-time between digits, leading-zero blanking and per-digit blink.

Parameters:
- DEAD_CYCLES, 4: clk cycles all anodes are forced off after every scan change (1..255).
- BLINK_FRAMES, 64: number of complete scan frames per blink half-period (2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- scan  in  2  digit select from the clock divider; 0 = rightmost digit
- hex_in  in  16  value to display; nibble i goes to digit i
- point_in  in  4  decimal point per digit, 1 = lit
- load  in  1  single-cycle strobe that captures hex_in/point_in
- blank_lz  in  1  1 = suppress leading zeros
- blink_mask  in  4  1 = digit i blinks
- pending  out  1  captured value not yet on the display
- AN  out  4  anodes, active-low, registered
- SEGMENT  out  8  segments, active-low, registered; bit0=a..bit6=g, bit7=dp

Behaviour:
- Reset values (async): AN=4'hF, SEGMENT=8'hFF, pending=0.
- Reset also clears the following to 0: display/shadow registers, scan_q (seeded 0), frame counter, blink_phase, dead counter.
- Scan edge detection:
  - scan_q registers scan every cycle; scan_chg = (scan != scan_q).
  - frame_start = scan_chg && scan==0.
- Load:
  - load=1 captures hex_in/point_in into the shadow register and sets pending=1. A later load before frame_start overwrites the shadow (last wins).
  - On frame_start with pending=1: the display register takes the shadow and pending clears.
  - If load coincides with frame_start, hex_in/point_in go straight to the display register and pending stays 0.
- Dead time:
  - On scan_chg the dead counter loads DEAD_CYCLES; it decrements each cycle while nonzero.
  - While the dead counter is nonzero, or scan_chg is active, the next AN=4'hF.
- Digit output, registered with 1-cycle latency from scan:
  - AN = ~(4'b0001 << scan).
  - SEGMENT = {~dp[scan], font(nibble[scan])}.
  - Font (active-low, dp off), 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Leading-zero blank (blank_lz=1):
  - Digit i (i=3..1) is blank if its nibble and all higher nibbles are 0. Digit 0 is never blanked.
  - A blanked digit outputs SEGMENT=8'hFF, including dp; AN is still asserted.
- Blink:
  - The frame counter increments on each frame_start.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - While blink_phase=1 and blink_mask[scan]=1: SEGMENT=8'hFF and AN=4'hF for that digit.
- Scan jumps (non-sequential change, e.g. 1->3) are treated as ordinary scan changes. frame_start fires only on entry to 0.
- rst mid-frame: outputs go dark immediately. The display shows 0000 (or only "0" with blank_lz) after the first post-reset scan change.

Test Plan:
1. Reset, then drive scan 0,1,2,3 (hold each 20 cycles), DEAD_CYCLES=4, blank_lz=0 -> AN=F for 5 cycles after each change, then E,D,B,7; SEGMENT=C0 on every digit.
2. Load 16'h1234 while scan=2 -> pending=1, digits still show 0 for scan=2,3. After scan->0: pending=0; digits 0..3 show 99,B0,A4,F9.
3. Load 16'hABCD exactly on the cycle scan goes 3->0 -> pending never asserts; digit0 shows A1 in that same frame.
4. hex_in=16'h0050, blank_lz=1, point_in=4'b0010 -> digit3,2 = FF, digit1 = 12 (5 with dp), digit0 = C0. Then hex_in=16'h0000 -> digits 3..1 FF, digit0 C0.
5. BLINK_FRAMES=2, blink_mask=4'b0001, hex 16'h1111:
   - Frames 0-1: digit0 AN=E / SEGMENT=F9.
   - Frames 2-3: digit0 AN=F / SEGMENT=FF, while digits 1-3 stay lit.
   - Frame 4: digit0 lit again.
6. Assert rst for 1 cycle while scan=2 with pending=1 -> same cycle AN=F, SEGMENT=FF, pending=0; next frame displays 0000.
